serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 15 +
 rtl/serial_adder_ctrl_half_adder_cell.sv | 17 +
 rtl/serial_adder_defs.vh | 12 +
 rtl/serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
// Types shared by the serial adder controller: the FSM state enum, built from
// the encodings in serial_adder_defs.vh.
package serial_adder_ctrl_pkg;

`include "serial_adder_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `SA_ST_IDLE,
    ST_P1   = `SA_ST_P1,
    ST_P2   = `SA_ST_P2,
    ST_DONE = `SA_ST_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_half_adder_cell.sv
// half_adder_cell
// Single-bit half adder, shared by both passes of every bit in the serial
// adder.
//   x, y : operand bits
//   s    : x ^ y
//   c    : x & y
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_defs.vh
// Shared state encodings for the serial adder controller.
// Included by serial_adder_ctrl_pkg so the FSM enum and any other user agree
// on one set of codes.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH

`define SA_ST_IDLE 2'd0
`define SA_ST_P1   2'd1
`define SA_ST_P2   2'd2
`define SA_ST_DONE 2'd3

`endif

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial unsigned adder, LSB first. Each bit takes two passes through one
// shared half adder: P1 forms propagate/generate from the operand bits, P2
// folds in the running carry and writes the sum bit.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an addition (accepted only in IDLE)
//   a, b       : WIDTH-bit unsigned operands, latched on accept
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, sum/cout (and ovf) valid
//   sum, cout  : registered result and carry out of the MSB
//   ovf        : signed overflow, present only with SERIAL_ADDER_OVF_EN
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf output.
//
// state   | meaning
// IDLE    | waiting for start
// P1      | half adder on a[i], b[i] -> p, g1
// P2      | half adder on p, carry -> sum[i]; carry = g1 | g2
// DONE    | done pulse, then back to IDLE
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             p_q;
  logic             g1_q;

  logic ha_x;
  logic ha_y;
  logic ha_s;
  logic ha_c;
  logic carry_nxt;

  // P2 reuses the cell on (p, carry); every other state presents the
  // current operand bits, which is what P1 consumes.
  always_comb begin
    ha_x = a_q[idx];
    ha_y = b_q[idx];
    if (state == ST_P2) begin
      ha_x = p_q;
      ha_y = carry;
    end
  end

  assign carry_nxt = g1_q | ha_c;

  half_adder_cell u_ha (
    .x (ha_x),
    .y (ha_y),
    .s (ha_s),
    .c (ha_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= 1'b0;
      g1_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_P1;
          end
        end
        ST_P1: begin
          p_q   <= ha_s;
          g1_q  <= ha_c;
          state <= ST_P2;
        end
        ST_P2: begin
          sum[idx] <= ha_s;
          carry    <= carry_nxt;
          if (idx == LAST_IDX) begin
            // Results are registered on the way into DONE so they are
            // already valid while done is high.
            cout  <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB here
            ovf   <= carry ^ carry_nxt;
`endif
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_P1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called #1 after the accepting edge. Scrambles operands while busy,
  // measures latency, checks the result against plain arithmetic, then
  // checks the done pulse width and that the result holds.
  task automatic wait_done(input logic [W-1:0] x, input logic [W-1:0] y);
    int           cyc;
    logic [W:0]   full;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    full     = {1'b0, x} + {1'b0, y};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    chk("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * W) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(2 * W));
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("cout", 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'((x[W-1] == y[W-1]) && (exp_sum[W-1] != x[W-1])));
`endif
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(exp_sum));
    chk("cout_hold", 32'(cout), 32'(exp_cout));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(x, y);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd3, 8'd5);
    run_op(8'd255, 8'd1);
    run_op(8'd0, 8'd0);
    run_op(8'd127, 8'd1);
    run_op(8'd200, 8'd100);
    run_op(8'd255, 8'd255);

    // start held high: operands change mid-flight, start during DONE is
    // ignored, then the next operation is taken from IDLE.
    @(negedge clk);
    a     = 8'd77;
    b     = 8'd99;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(8'd77, 8'd99);
    a = 8'd150;
    b = 8'd160;
    @(posedge clk);
    #1;
    wait_done(8'd150, 8'd160);
    start = 1'b0;
    @(posedge clk);
    #1;

    // reset during bit 3 of 10+20
    @(negedge clk);
    a     = 8'd10;
    b     = 8'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd7, 8'd9);

    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, limit 2000000 ns");
    $fatal(1, "timeout");
  end

endmodule
